// File: rtl/serial_rx_if.sv
// Serial receive line plus the decoded-byte outputs of serial_rx.
// The slave modport is the receiver side; the master modport drives RxD and observes results.
interface serial_rx_if;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_idle;

    modport master (
        output RxD,
        input  RxD_data,
        input  RxD_data_ready,
        input  RxD_frame_error,
        input  RxD_idle
    );

    modport slave (
        input  RxD,
        output RxD_data,
        output RxD_data_ready,
        output RxD_frame_error,
        output RxD_idle
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver using a fractional oversample tick; result pulses arrive one clk after the stop-bit sample.
// No back-pressure: RxD_data holds until the next good byte, and a missed ready pulse loses that byte.
module serial_rx #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8,
    parameter int AccWidth     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_rx_if.slave  rx
);
    localparam longint IncL = ((longint'(Baud) * longint'(Oversampling) * (longint'(1) << AccWidth))
                               + longint'(ClkFrequency) / 2) / longint'(ClkFrequency);
    localparam logic [AccWidth:0] Inc = (AccWidth+1)'(IncL);
    localparam int CntW    = $clog2(Oversampling);
    localparam int IdleMax = 10 * Oversampling;
    localparam int IdleW   = $clog2(IdleMax + 1);
    localparam logic [CntW-1:0]  CntHalf = CntW'(Oversampling / 2 - 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(Oversampling - 1);
    localparam logic [IdleW-1:0] IdleSat = IdleW'(IdleMax);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic [1:0]          r_sync;
    logic [AccWidth:0]   r_acc;
    state_t              r_state, w_state_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic [2:0]          r_bit, w_bit_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_rdy, w_rdy_nxt;
    logic                r_ferr, w_ferr_nxt;
    logic [IdleW-1:0]    r_idle_cnt, w_idle_nxt;
    logic                w_rxs;
    logic                w_tick;

    assign w_rxs  = r_sync[1];
    assign w_tick = r_acc[AccWidth];

    // Accumulator carry is the tick; the carry bit is dropped before each add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_acc  <= '0;
        end else begin
            r_sync <= {r_sync[0], rx.RxD};
            r_acc  <= {1'b0, r_acc[AccWidth-1:0]} + Inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_rdy      <= 1'b0;
            r_ferr     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_rdy      <= w_rdy_nxt;
            r_ferr     <= w_ferr_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_rdy_nxt   = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_idle_nxt  = (r_state == S_IDLE) ? r_idle_cnt : '0;

        if (w_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                        w_idle_nxt  = '0;
                    end else if (r_idle_cnt != IdleSat) begin
                        w_idle_nxt  = r_idle_cnt + 1'b1;
                    end
                end
                S_START: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CntHalf) begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    // cnt is exactly log2(Oversampling) wide, so the increment wraps at the mid-bit tick.
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        w_shift_nxt = {w_rxs, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        if (w_rxs) begin
                            w_data_nxt  = r_shift;
                            w_rdy_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign rx.RxD_data        = r_data;
    assign rx.RxD_data_ready  = r_rdy;
    assign rx.RxD_frame_error = r_ferr;
    assign rx.RxD_idle        = (r_state == S_IDLE) && (r_idle_cnt == IdleSat);
endmodule
